mem_access_ctrl: RTL

Memory-stage access controller between the EX/MEM pipeline register and the MEM/WB pipeline register. It issues one-cycle read/write/dump requests to the variable-latency data memory and holds the pipeline stalled until the memory reports completion. It delivers the read data to MEM/WB in the cycle the instruction leaves the stage. It also detects misaligned, illegal, failed and timed-out accesses.

---
 rtl/mem_access_ctrl_pkg.sv | 13 +
 rtl/dff.sv | 22 ++
 rtl/mem_access_ctrl_wait_cnt.sv | 36 +++
 rtl/mem_access_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller:
// FSM state encoding and default parameter values.
package mem_access_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;
    localparam logic [1:0] ST_ERR  = 2'b11;

    localparam int DEFAULT_DATA_W  = 16;
    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/dff.sv
// Generic enabled D flip-flop with asynchronous active-high reset to RST_VAL.
module dff #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Load d when enabled; reset forces the reset value immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_access_ctrl_wait_cnt.sv
// Wait-cycle counter for outstanding memory accesses. Cleared when an access
// is issued, incremented once per WAIT cycle, saturating at TIMEOUT-1.
// tc flags the increment that brings the count to TIMEOUT-1, so the FSM
// can leave WAIT on the same edge the counter reaches its terminal value.
module mem_wait_cnt
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(TIMEOUT - 2);

    logic [CNT_W-1:0] cnt;

    // Count WAIT cycles; never wraps past TIMEOUT-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = en && (cnt == PRE);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller. Issues one-cycle read/write/dump strobes
// to a variable-latency data memory, stalls the pipeline while an access is
// outstanding, hands read data to MEM/WB as the instruction leaves the stage
// and traps misaligned, conflicting, failed and timed-out accesses.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              nop_in,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic              halt_in,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    input  logic              mem_stall,
    input  logic              mem_err,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mem_createdump,
    output logic [DATA_W-1:0] rdata_out,
    output logic              stall_out,
    output logic              err_out
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [DATA_W-1:0] hold;
    logic              hold_en;
    logic              err_q;
    logic              err_set;
    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_tc;

    logic              access;
    logic              dump_req;
    logic              illegal;

    // Address and store data go straight through; only strobes qualify them.
    assign mem_addr  = req_addr;
    assign mem_wdata = req_wdata;
    assign err_out   = err_q;

    // A HALT only dumps when it is not sharing the slot with a load/store.
    assign access   = ~nop_in & (req_rd | req_wr);
    assign dump_req = ~nop_in & halt_in & ~req_rd & ~req_wr;
    assign illegal  = access & ((req_rd & req_wr) | req_addr[0]);

    dff #(.W(2), .RST_VAL(ST_IDLE)) u_state (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (state_nxt),
        .q   (state)
    );

    dff #(.W(DATA_W), .RST_VAL('0)) u_hold (
        .clk (clk),
        .rst (rst),
        .en  (hold_en),
        .d   (mem_rdata),
        .q   (hold)
    );

    // Once set, only reset clears the error flag.
    dff #(.W(1), .RST_VAL(1'b0)) u_err (
        .clk (clk),
        .rst (rst),
        .en  (err_set),
        .d   (1'b1),
        .q   (err_q)
    );

    mem_wait_cnt #(.TIMEOUT(TIMEOUT)) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    // Next-state, strobe, stall and read-data selection.
    always_comb begin
        state_nxt      = state;
        mem_rd         = 1'b0;
        mem_wr         = 1'b0;
        mem_createdump = 1'b0;
        stall_out      = 1'b0;
        rdata_out      = hold;
        hold_en        = 1'b0;
        err_set        = 1'b0;
        cnt_clr        = 1'b0;
        cnt_en         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (illegal) begin
                    stall_out = 1'b1;
                    err_set   = 1'b1;
                    state_nxt = ST_ERR;
                end else if (access) begin
                    if (mem_stall) begin
                        // Memory cannot take it yet; hold the pipe and retry.
                        stall_out = 1'b1;
                    end else begin
                        mem_rd = req_rd;
                        mem_wr = req_wr;
                        if (mem_done && mem_err) begin
                            stall_out = 1'b1;
                            err_set   = 1'b1;
                            state_nxt = ST_ERR;
                        end else if (mem_done) begin
                            // Hit: forward the memory data combinationally.
                            rdata_out = mem_rdata;
                        end else begin
                            stall_out = 1'b1;
                            cnt_clr   = 1'b1;
                            state_nxt = ST_WAIT;
                        end
                    end
                end else if (dump_req) begin
                    mem_createdump = 1'b1;
                end
            end
            ST_WAIT: begin
                stall_out = 1'b1;
                cnt_en    = 1'b1;
                if (mem_done && mem_err) begin
                    err_set   = 1'b1;
                    state_nxt = ST_ERR;
                end else if (mem_done) begin
                    hold_en   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (cnt_tc) begin
                    err_set   = 1'b1;
                    state_nxt = ST_ERR;
                end
            end
            ST_DONE: begin
                // Instruction leaves the stage at this edge; do not reissue.
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                stall_out = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Reset silences every strobe and the stall, and hides any bypass.
        if (rst) begin
            mem_rd         = 1'b0;
            mem_wr         = 1'b0;
            mem_createdump = 1'b0;
            stall_out      = 1'b0;
            rdata_out      = hold;
        end
    end

endmodule
